// File: rtl/wb_arb_pkg.sv
// Shared types and field helpers for the two-requester DDR write-path arbiter.
// Address-FIFO entries are packed as {src, rd, addr}.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    ADDR = 2'd2
  } state_e;

  function automatic int af_src_pos(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic int af_rd_pos(input int addr_w);
    return addr_w;
  endfunction

  function automatic int beat_cnt_w(input int burst_len);
    return (burst_len > 2) ? $clog2(burst_len) : 1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: combinational one-hot grant from a registered
// priority pointer that only advances when the served command completes.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       update_i,
  input  logic       last_served_i,
  output logic [1:0] grant_o
);

  logic ptr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else if (update_i) begin
      ptr_q <= ~last_served_i;
    end
  end

  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = ptr_q ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Shares the DDR write buffer and address FIFO between two requesters.
// Write data is fully buffered before its address entry is pushed.
module wb_write_arbiter
  import wb_arb_pkg::*;
#(
  parameter int ADDR_W    = 28,
  parameter int BURST_LEN = 2,
  parameter int DATA_W    = 144
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [1:0]          CmdValid,
  input  logic [1:0]          CmdRead,
  input  logic [2*ADDR_W-1:0] CmdAddr,
  output logic [1:0]          CmdReady,
  input  logic [1:0]          WDValid,
  input  logic [2*DATA_W-1:0] WDin,
  output logic [1:0]          WDReady,
  output logic [ADDR_W+1:0]   AFdata,
  output logic                AFwrite,
  input  logic                AFfull,
  output logic [DATA_W-1:0]   WBdata,
  output logic                WBwrite,
  input  logic                WBfull
);

  localparam int BEAT_W  = beat_cnt_w(BURST_LEN);
  localparam int SRC_POS = af_src_pos(ADDR_W);
  localparam int RD_POS  = af_rd_pos(ADDR_W);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                src_q, src_d;
  logic                rd_q, rd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          grant;
  logic                win;

  rr_arb2 u_rr_arb2 (
    .clk          (Clk),
    .reset        (Reset),
    .req_i        (CmdValid & {2{state_q == IDLE}}),
    .update_i     (AFwrite),
    .last_served_i(src_q),
    .grant_o      (grant)
  );

  assign win = grant[1];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // NOTE: command registers are only read after being loaded on a grant, so
  // they need no reset; leaving it off keeps reset fan-out to control state.
  always_ff @(posedge Clk) begin
    src_q  <= src_d;
    rd_q   <= rd_d;
    addr_q <= addr_d;
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    src_d   = src_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (|grant) begin
          src_d   = win;
          rd_d    = CmdRead[win];
          addr_d  = win ? CmdAddr[2*ADDR_W-1:ADDR_W] : CmdAddr[ADDR_W-1:0];
          state_d = CmdRead[win] ? ADDR : DATA;
        end
      end
      DATA: begin
        if (WBwrite) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = ADDR;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      ADDR: begin
        if (AFwrite) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes are forced low while Reset is held so an abandoned burst never
  // leaks a beat or address entry during the reset cycle itself.
  always_comb begin
    CmdReady = 2'b00;
    WDReady  = 2'b00;
    WBwrite  = 1'b0;
    AFwrite  = 1'b0;
    WBdata   = src_q ? WDin[2*DATA_W-1:DATA_W] : WDin[DATA_W-1:0];
    AFdata   = '0;
    AFdata[SRC_POS]      = src_q;
    AFdata[RD_POS]       = rd_q;
    AFdata[ADDR_W-1:0]   = addr_q;
    if (!Reset) begin
      case (state_q)
        IDLE: CmdReady = grant;
        DATA: begin
          WDReady[src_q] = !WBfull;
          WBwrite        = WDValid[src_q] & !WBfull;
        end
        ADDR:    AFwrite = !AFfull;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter: directed scenarios plus a
// randomized run, all scored against a transaction-level model.
module tb_wb_write_arbiter;

  localparam int ADDR_W    = 28;
  localparam int BURST_LEN = 2;
  localparam int DATA_W    = 144;

  typedef struct packed {
    logic                             rd;
    logic [ADDR_W-1:0]                addr;
    logic [BURST_LEN-1:0][DATA_W-1:0] beats;
  } cmd_t;

  logic                clk = 1'b0;
  logic                Reset;
  logic [1:0]          CmdValid, CmdRead, CmdReady, WDValid, WDReady;
  logic [2*ADDR_W-1:0] CmdAddr;
  logic [2*DATA_W-1:0] WDin;
  logic [ADDR_W+1:0]   AFdata;
  logic                AFwrite, AFfull, WBwrite, WBfull;
  logic [DATA_W-1:0]   WBdata;

  wb_write_arbiter #(.ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN), .DATA_W(DATA_W)) dut (
    .Clk(clk), .Reset(Reset), .CmdValid(CmdValid), .CmdRead(CmdRead), .CmdAddr(CmdAddr),
    .CmdReady(CmdReady), .WDValid(WDValid), .WDin(WDin), .WDReady(WDReady),
    .AFdata(AFdata), .AFwrite(AFwrite), .AFfull(AFfull), .WBdata(WBdata),
    .WBwrite(WBwrite), .WBfull(WBfull)
  );

  always #5 clk = ~clk;

  // Stimulus controls
  bit rst_ctl, wbfull_ctl, affull_ctl, noise_en, throttle_en;

  // Requester-side queues: pending commands and granted write beats
  cmd_t              cq0[$], cq1[$];
  logic [DATA_W-1:0] dq0[$], dq1[$];

  // Transaction-level model of the shared path
  bit                m_busy, m_src, m_rd, m_ptr;
  logic [ADDR_W-1:0] m_addr;
  int                m_left;

  // Observations of the DUT
  int                grant_log[$];
  logic [ADDR_W+1:0] af_log[$];
  logic [1:0]        obs_cr, obs_wdr;
  logic              obs_wbw, obs_afw;
  logic [DATA_W-1:0] obs_wbd;
  logic [ADDR_W+1:0] obs_afd;

  int n_checks = 0;
  int n_err    = 0;

  function automatic logic [DATA_W-1:0] rand_beat();
    logic [159:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return r[DATA_W-1:0];
  endfunction

  function automatic cmd_t new_cmd(input logic rd, input logic [ADDR_W-1:0] addr);
    cmd_t c;
    c.rd   = rd;
    c.addr = addr;
    for (int k = 0; k < BURST_LEN; k++) c.beats[k] = rand_beat();
    return c;
  endfunction

  task automatic step();
    logic [1:0]        exp_cr, exp_wdr;
    logic              exp_wbw, exp_afw;
    logic [DATA_W-1:0] exp_wbd;
    logic [ADDR_W+1:0] exp_afd;
    int                w;
    cmd_t              c;
    @(negedge clk);
    Reset  = rst_ctl;
    WBfull = wbfull_ctl;
    AFfull = affull_ctl;
    CmdValid = {cq1.size() != 0, cq0.size() != 0};
    CmdRead  = 2'($urandom());
    CmdAddr  = {ADDR_W'($urandom()), ADDR_W'($urandom())};
    WDin     = {rand_beat(), rand_beat()};
    if (cq0.size() != 0) begin CmdRead[0] = cq0[0].rd; CmdAddr[ADDR_W-1:0] = cq0[0].addr; end
    if (cq1.size() != 0) begin CmdRead[1] = cq1[0].rd; CmdAddr[2*ADDR_W-1:ADDR_W] = cq1[0].addr; end
    if (dq0.size() != 0) begin
      WDValid[0] = throttle_en ? 1'($urandom_range(0, 1)) : 1'b1;
      WDin[DATA_W-1:0] = dq0[0];
    end else begin
      WDValid[0] = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    if (dq1.size() != 0) begin
      WDValid[1] = throttle_en ? 1'($urandom_range(0, 1)) : 1'b1;
      WDin[2*DATA_W-1:DATA_W] = dq1[0];
    end else begin
      WDValid[1] = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    #1;
    exp_cr = 2'b00; exp_wdr = 2'b00; exp_wbw = 1'b0; exp_afw = 1'b0; w = 0;
    exp_wbd = '0;
    exp_afd = {m_src, m_rd, m_addr};
    if (!Reset) begin
      if (!m_busy) begin
        if (CmdValid != 2'b00) begin
          w = (CmdValid == 2'b11) ? int'(m_ptr) : (CmdValid[1] ? 1 : 0);
          exp_cr = (w == 1) ? 2'b10 : 2'b01;
        end
      end else if (m_left > 0) begin
        exp_wdr[m_src] = !WBfull;
        exp_wbw = WDValid[m_src] & !WBfull;
        exp_wbd = m_src ? dq1[0] : dq0[0];
      end else begin
        exp_afw = !AFfull;
      end
    end
    n_checks++;
    if (CmdReady !== exp_cr) begin
      n_err++; $display("FAIL cmd_ready t=%0t got=%b exp=%b", $time, CmdReady, exp_cr);
    end
    n_checks++;
    if (WDReady !== exp_wdr) begin
      n_err++; $display("FAIL wd_ready t=%0t got=%b exp=%b", $time, WDReady, exp_wdr);
    end
    n_checks++;
    if (WBwrite !== exp_wbw) begin
      n_err++; $display("FAIL wb_write t=%0t got=%b exp=%b", $time, WBwrite, exp_wbw);
    end
    n_checks++;
    if (AFwrite !== exp_afw) begin
      n_err++; $display("FAIL af_write t=%0t got=%b exp=%b", $time, AFwrite, exp_afw);
    end
    if (exp_wbw) begin
      n_checks++;
      if (WBdata !== exp_wbd) begin
        n_err++; $display("FAIL wb_data t=%0t got=%h exp=%h", $time, WBdata, exp_wbd);
      end
    end
    if (exp_afw) begin
      n_checks++;
      if (AFdata !== exp_afd) begin
        n_err++; $display("FAIL af_data t=%0t got=%h exp=%h", $time, AFdata, exp_afd);
      end
    end
    obs_cr = CmdReady; obs_wdr = WDReady; obs_wbw = WBwrite; obs_afw = AFwrite;
    obs_wbd = WBdata; obs_afd = AFdata;
    if (CmdReady == 2'b01) grant_log.push_back(0);
    else if (CmdReady == 2'b10) grant_log.push_back(1);
    else if (CmdReady != 2'b00) grant_log.push_back(9);
    if (AFwrite === 1'b1) af_log.push_back(AFdata);
    // Advance the model
    if (Reset) begin
      m_busy = 1'b0; m_ptr = 1'b0; m_left = 0;
      dq0.delete(); dq1.delete();
    end else if (!m_busy) begin
      if (exp_cr != 2'b00) begin
        if (w == 1) c = cq1.pop_front(); else c = cq0.pop_front();
        m_busy = 1'b1; m_src = w[0]; m_rd = c.rd; m_addr = c.addr;
        m_left = c.rd ? 0 : BURST_LEN;
        if (!c.rd) begin
          for (int k = 0; k < BURST_LEN; k++) begin
            if (w == 1) dq1.push_back(c.beats[k]); else dq0.push_back(c.beats[k]);
          end
        end
      end
    end else if (m_left > 0) begin
      if (exp_wbw) begin
        if (m_src) void'(dq1.pop_front()); else void'(dq0.pop_front());
        m_left--;
      end
    end else if (exp_afw) begin
      m_busy = 1'b0;
      m_ptr  = ~m_src;
    end
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while ((cq0.size() != 0 || cq1.size() != 0 || m_busy) && n < budget) begin
      step();
      n++;
    end
    n_checks++;
    if (cq0.size() != 0 || cq1.size() != 0 || m_busy) begin
      n_err++; $display("FAIL drain_timeout got=busy exp=idle within %0d cycles", budget);
    end
  endtask

  task automatic check_all_zero(input string name);
    n_checks++;
    if ({obs_cr, obs_wdr, obs_wbw, obs_afw} !== 6'b0) begin
      n_err++;
      $display("FAIL %s got cr=%b wdr=%b wbw=%b afw=%b exp=all 0", name, obs_cr, obs_wdr, obs_wbw, obs_afw);
    end
  endtask

  task automatic test_reset();
    rst_ctl = 1'b1;
    step(); step();
    check_all_zero("reset_hold");
    rst_ctl = 1'b0;
    step();
    check_all_zero("reset_release");
  endtask

  task automatic test_read_single();
    cq1.push_back(new_cmd(1'b1, 28'h0000ABC));
    step();
    n_checks++;
    if (obs_cr !== 2'b10) begin n_err++; $display("FAIL read_grant got=%b exp=10", obs_cr); end
    step();
    n_checks++;
    if (obs_afw !== 1'b1 || obs_afd !== {1'b1, 1'b1, 28'h0000ABC} || obs_wbw !== 1'b0) begin
      n_err++; $display("FAIL read_af got afw=%b afd=%h wbw=%b exp afw=1 afd=%h wbw=0",
                        obs_afw, obs_afd, obs_wbw, {1'b1, 1'b1, 28'h0000ABC});
    end
    step();
    n_checks++;
    if (obs_afw !== 1'b0) begin n_err++; $display("FAIL read_af_once got=%b exp=0", obs_afw); end
  endtask

  task automatic test_alternating();
    logic [ADDR_W-1:0] a[4];
    int gb, ab;
    gb = grant_log.size(); ab = af_log.size();
    for (int k = 0; k < 4; k++) a[k] = ADDR_W'(32'h0100000 + k * 16);
    cq0.push_back(new_cmd(1'b0, a[0])); cq1.push_back(new_cmd(1'b0, a[1]));
    cq0.push_back(new_cmd(1'b0, a[2])); cq1.push_back(new_cmd(1'b0, a[3]));
    run_until_idle(200);
    n_checks++;
    if (grant_log.size() - gb != 4 || af_log.size() - ab != 4) begin
      n_err++; $display("FAIL alt_count got grants=%0d af=%0d exp=4/4", grant_log.size() - gb, af_log.size() - ab);
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (grant_log[gb + k] != k % 2 || af_log[ab + k] !== {1'(k % 2), 1'b0, a[k]}) begin
          n_err++; $display("FAIL alt_order[%0d] got grant=%0d af=%h exp grant=%0d af=%h",
                            k, grant_log[gb + k], af_log[ab + k], k % 2, {1'(k % 2), 1'b0, a[k]});
        end
      end
    end
  endtask

  task automatic test_write_single();
    cmd_t c;
    c = new_cmd(1'b0, 28'h0123450);
    cq0.push_back(c);
    step();
    n_checks++;
    if (obs_cr !== 2'b01) begin n_err++; $display("FAIL wr_grant got=%b exp=01", obs_cr); end
    for (int k = 0; k < BURST_LEN; k++) begin
      step();
      n_checks++;
      if (obs_wbw !== 1'b1 || obs_wbd !== c.beats[k]) begin
        n_err++; $display("FAIL wr_beat%0d got wbw=%b data=%h exp wbw=1 data=%h", k, obs_wbw, obs_wbd, c.beats[k]);
      end
    end
    step();
    n_checks++;
    if (obs_afw !== 1'b1 || obs_afd !== {1'b0, 1'b0, 28'h0123450}) begin
      n_err++; $display("FAIL wr_af got afw=%b afd=%h exp afw=1 afd=%h", obs_afw, obs_afd, {2'b00, 28'h0123450});
    end
  endtask

  task automatic test_wbfull_stall();
    cmd_t c;
    c = new_cmd(1'b0, 28'h0BEEF00);
    cq0.push_back(c);
    step();
    step();
    n_checks++;
    if (obs_wbw !== 1'b1 || obs_wbd !== c.beats[0]) begin
      n_err++; $display("FAIL stall_beat0 got wbw=%b exp=1", obs_wbw);
    end
    wbfull_ctl = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      n_checks++;
      if (obs_wdr !== 2'b00 || obs_wbw !== 1'b0 || obs_afw !== 1'b0) begin
        n_err++; $display("FAIL stall_hold%0d got wdr=%b wbw=%b afw=%b exp 00/0/0", k, obs_wdr, obs_wbw, obs_afw);
      end
    end
    wbfull_ctl = 1'b0;
    step();
    n_checks++;
    if (obs_wbw !== 1'b1 || obs_wbd !== c.beats[1]) begin
      n_err++; $display("FAIL stall_beat1 got wbw=%b data=%h exp wbw=1 data=%h", obs_wbw, obs_wbd, c.beats[1]);
    end
    step();
    n_checks++;
    if (obs_afw !== 1'b1 || obs_afd !== {2'b00, 28'h0BEEF00}) begin
      n_err++; $display("FAIL stall_af got afw=%b afd=%h exp afw=1 afd=%h", obs_afw, obs_afd, {2'b00, 28'h0BEEF00});
    end
  endtask

  task automatic test_affull_stall();
    int ab, hits;
    ab = af_log.size();
    cq1.push_back(new_cmd(1'b1, 28'h0777770));
    step();
    n_checks++;
    if (obs_cr !== 2'b10) begin n_err++; $display("FAIL af_stall_grant got=%b exp=10", obs_cr); end
    affull_ctl = 1'b1;
    cq0.push_back(new_cmd(1'b0, 28'h0555550));
    for (int k = 0; k < 5; k++) begin
      step();
      n_checks++;
      if (obs_afw !== 1'b0 || obs_cr !== 2'b00) begin
        n_err++; $display("FAIL af_stall_hold%0d got afw=%b cr=%b exp 0/00", k, obs_afw, obs_cr);
      end
    end
    affull_ctl = 1'b0;
    step();
    n_checks++;
    if (obs_afw !== 1'b1 || obs_afd !== {2'b11, 28'h0777770}) begin
      n_err++; $display("FAIL af_stall_push got afw=%b afd=%h exp afw=1 afd=%h", obs_afw, obs_afd, {2'b11, 28'h0777770});
    end
    step();
    n_checks++;
    if (obs_cr !== 2'b01) begin n_err++; $display("FAIL af_stall_next got=%b exp=01", obs_cr); end
    run_until_idle(50);
    hits = 0;
    for (int k = ab; k < af_log.size(); k++) if (af_log[k] === {2'b11, 28'h0777770}) hits++;
    n_checks++;
    if (hits != 1) begin n_err++; $display("FAIL af_stall_once got=%0d exp=1", hits); end
  endtask

  task automatic test_reset_mid_burst();
    int ab, stale;
    cq1.push_back(new_cmd(1'b0, 28'h0DEAD00));
    step();
    step();
    n_checks++;
    if (obs_wbw !== 1'b1) begin n_err++; $display("FAIL rst_beat0 got=%b exp=1", obs_wbw); end
    rst_ctl = 1'b1;
    step();
    check_all_zero("rst_mid_cycle");
    rst_ctl = 1'b0;
    step();
    check_all_zero("rst_mid_after");
    ab = af_log.size();
    cq0.push_back(new_cmd(1'b0, 28'h0000100));
    cq1.push_back(new_cmd(1'b0, 28'h0000200));
    step();
    n_checks++;
    if (obs_cr !== 2'b01) begin n_err++; $display("FAIL rst_regrant got=%b exp=01", obs_cr); end
    run_until_idle(50);
    stale = 0;
    for (int k = ab; k < af_log.size(); k++) if (af_log[k][ADDR_W-1:0] === 28'h0DEAD00) stale++;
    n_checks++;
    if (stale != 0 || af_log.size() - ab != 2) begin
      n_err++; $display("FAIL rst_stale got stale=%0d entries=%0d exp 0/2", stale, af_log.size() - ab);
    end
  endtask

  task automatic test_random();
    int ab, issued;
    ab = af_log.size(); issued = 0;
    noise_en = 1'b1; throttle_en = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cq0.size() < 3 && $urandom_range(0, 3) == 0) begin
        cq0.push_back(new_cmd(1'($urandom_range(0, 1)), ADDR_W'($urandom()))); issued++;
      end
      if (cq1.size() < 3 && $urandom_range(0, 3) == 0) begin
        cq1.push_back(new_cmd(1'($urandom_range(0, 1)), ADDR_W'($urandom()))); issued++;
      end
      wbfull_ctl = ($urandom_range(0, 3) == 0);
      affull_ctl = ($urandom_range(0, 3) == 0);
      step();
    end
    wbfull_ctl = 1'b0; affull_ctl = 1'b0;
    run_until_idle(500);
    noise_en = 1'b0; throttle_en = 1'b0;
    n_checks++;
    if (af_log.size() - ab != issued) begin
      n_err++; $display("FAIL rand_af_count got=%0d exp=%0d", af_log.size() - ab, issued);
    end
  endtask

  initial begin
    Reset = 1'b1; CmdValid = '0; CmdRead = '0; CmdAddr = '0; WDValid = '0; WDin = '0;
    AFfull = 1'b0; WBfull = 1'b0;
    m_busy = 1'b0; m_src = 1'b0; m_rd = 1'b0; m_ptr = 1'b0; m_addr = '0; m_left = 0;
    test_reset();
    test_read_single();
    test_alternating();
    test_write_single();
    test_wbfull_stall();
    test_affull_stall();
    test_reset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Shares the DDR write path (write buffer plus address FIFO) between two requesters, e.g. the CPU pipeline and the DMA/host port, on a single clock.
- Grants one command at a time, round-robin.
- For writes: streams BURST_LEN data beats into the write buffer first, then pushes the address-FIFO entry, so the DDR sequencer never sees a write address whose data is not yet buffered.
- Reads go straight to the address FIFO, tagged with the source ID for response routing.

Parameters:
- ADDR_W, 28, command address width (burst-aligned DDR address)
- BURST_LEN, 2, 144-bit data beats per write command (2..8)
- DATA_W, 144, write data width: 128 data bits plus 16 ECC/check bits

Ports:
- Clk  in  1  single clock for all logic
- Reset  in  1  synchronous, active-high
- CmdValid  in  2  per-requester command valid (bit i = requester i)
- CmdRead  in  2  per-requester command type: 1 = read, 0 = write
- CmdAddr  in  2*ADDR_W  per-requester address; requester i occupies slice i
- CmdReady  out  2  command accepted (one-hot pulse)
- WDValid  in  2  per-requester write data valid
- WDin  in  2*DATA_W  per-requester write data
- WDReady  out  2  data beat accepted
- AFdata  out  ADDR_W+2  address-FIFO entry {src, rd, addr}
- AFwrite  out  1  address-FIFO push
- AFfull  in  1  address FIFO cannot accept
- WBdata  out  DATA_W  write-buffer data (WD of the write buffer)
- WBwrite  out  1  write-buffer push (WRen)
- WBfull  in  1  write buffer almost-full (Full)

Behaviour:
- Reset values: CmdReady=0, WDReady=0, AFwrite=0, WBwrite=0, state=IDLE, beat count=0, priority pointer=requester 0. AFdata and WBdata are don't-care when their strobes are low.
- IDLE:
  - If any CmdValid is set, the round-robin picker chooses winner w. When both are valid, the requester not served last wins.
  - CmdReady[w]=1 for exactly this cycle. Addr, rd and src=w are latched.
  - Next state is ADDR if rd, else DATA.
  - No other requester sees CmdReady in the same cycle.
- DATA:
  - WDReady[w] = !WBfull. WBwrite = WDValid[w] & !WBfull. WBdata = WDin slice w, passed through combinationally (zero latency).
  - Each accepted beat increments the beat count. On the beat where count = BURST_LEN-1: count clears, next state is ADDR.
  - WDValid from the non-granted requester is ignored (WDReady=0).
  - WBfull stalls indefinitely with no beat loss.
- ADDR:
  - AFwrite = !AFfull. AFdata = {src, rd, addr} from registers.
  - On push: pointer moves to the other requester, next state is IDLE.
  - AFfull stalls indefinitely.
- Latency, no stalls:
  - Read: CmdReady cycle 0, AFwrite cycle 1.
  - Write: CmdReady cycle 0, beats cycles 1..BURST_LEN, AFwrite cycle BURST_LEN+1.
  - A new command can be accepted in the cycle after AFwrite.
- Ordering: AF entries are pushed in grant order. For any write, all of its WB beats precede its AF entry.
- The pointer updates only on completion (AF push), not on grant.
- A single requester may issue back-to-back commands; it is re-granted whenever the other is idle.
- Simultaneous CmdValid with pointer=0 grants requester 0. The next simultaneous request grants requester 1.
- Reset mid-burst: FSM returns to IDLE at once and the partial burst is abandoned. The same Reset must clear the write buffer and address FIFO.
- WBfull is almost-full (128 free entries), so no burst can overflow it once started.

Decomposition:
- Shared package wb_arb_pkg holds:
  - state enum {IDLE, DATA, ADDR}
  - AF entry field offsets: src at ADDR_W+1, rd at ADDR_W, addr at ADDR_W-1:0
  - beat-counter width clog2(BURST_LEN)
- Sub-module rr_arb2: a 2-way round-robin picker with inputs req[1:0], last_served and an update strobe, and output a one-hot grant. It is combinational, with the pointer register inside it.

Test Plan:
- Read from requester 1 alone, addr=0x0000ABC: CmdReady=2'b10 at cycle 0, then AFwrite at cycle 1 with AFdata={1,1,0x0000ABC}. No WBwrite.
- Write from requester 0, addr=0x0123450, beats D0/D1: WBwrite at cycles 1 and 2 carrying D0 then D1. AFwrite at cycle 3 with {0,0,0x0123450}.
- Both requesters assert writes continuously for 4 commands: grants alternate 0,1,0,1. AF entries appear in grant order and each burst's WB beats are contiguous and uninterleaved.
- WBfull asserted after beat 0 for 10 cycles: WDReady=0 and WBwrite=0 throughout. Beat 1 is written in the cycle WBfull drops. The AF push follows one cycle later.
- AFfull held for 5 cycles during ADDR: AFwrite stays 0, no new CmdReady is issued, and the entry is pushed exactly once after release.
- Reset asserted between beat 0 and beat 1 of a write: all outputs are 0 in the next cycle. The following grant goes to requester 0, and no stale AF entry is issued.
